// File: rtl/bullet_manager.sv
// bullet_manager
//   Owns the three bullet slots. It accepts fire requests from the blockieee
//   column and moves live bullets up the playfield on a divided game tick.
//   On each tick it checks the cell a bullet is about to enter against the
//   ddaver grid, and it reports any hits.
//
// Ports
//   clk, rst_n      system clock, synchronous active-low reset
//   game_run        1 = play, 0 = pause (tick frozen, fire ignored)
//   blockPos        blockieee column, valid 0..COLS-1
//   fire_req        level fire request
//   fire_color      bullet colour, 0 = invalid
//   fire_ack        combinational pulse, high in the cycle a fire is accepted
//   ddState         ddaver grid, 0 = empty cell
//   bullState/X/Y   registered slot colour (0 = empty), column and row
//   hit_valid       per-slot one-cycle hit pulse
//   hit_row/col     grid cell of the hit
//   hit_color       colour of the bullet that hit
//
// Slot FSM
//   state   | meaning
//   FREE    | slot empty, bullState/X/Y all zero, may take a new fire
//   FLY     | bullet live, rises one row per tick until it hits or exits
module bullet_manager #(
  parameter int MOVE_DIV = 2500000,
  parameter int COOLDOWN = 1250000,
  parameter int SPAWN_Y  = 15,
  parameter int ROWS     = 5,
  parameter int COLS     = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_run,
  input  logic [3:0] blockPos,
  input  logic       fire_req,
  input  logic [1:0] fire_color,
  output logic       fire_ack,
  input  logic [2:0] ddState   [0:ROWS-1][0:COLS-1],
  output logic [1:0] bullState [0:2],
  output logic [3:0] bullX     [0:2],
  output logic [3:0] bullY     [0:2],
  output logic [2:0] hit_valid,
  output logic [2:0] hit_row   [0:2],
  output logic [2:0] hit_col   [0:2],
  output logic [1:0] hit_color [0:2]
);

  localparam logic [0:0] ST_FREE = 1'b0;
  localparam logic [0:0] ST_FLY  = 1'b1;

  localparam int TICK_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(MOVE_DIV - 1);
  localparam logic [COOL_W-1:0] COOL_LOAD = COOL_W'(COOLDOWN);
  localparam logic [3:0]        COLS_L    = 4'(COLS);
  localparam logic [3:0]        SPAWN_L   = 4'(SPAWN_Y);

  logic [0:0]        slot_st [0:2];
  logic [TICK_W-1:0] tick_cnt;
  logic [COOL_W-1:0] cool;
  logic              tick;
  logic              accept;
  logic              any_free;
  logic [2:0]        fire_slot;
  logic [3:0]        ny [0:2];
  logic [2:0]        cell_hit;

  assign tick = (tick_cnt == TICK_LAST) && game_run;

  // Lowest-index free slot, judged on registered state only, so a slot
  // freed on this edge cannot also be refilled on it.
  always_comb begin
    fire_slot = 3'b000;
    any_free  = 1'b0;
    for (int s = 0; s < 3; s++) begin
      if (slot_st[s] == ST_FREE && !any_free) begin
        fire_slot[s] = 1'b1;
        any_free     = 1'b1;
      end
    end
  end

  assign accept = rst_n && game_run && fire_req && (fire_color != 2'd0) &&
                  (blockPos < COLS_L) && (cool == '0) && any_free;
  assign fire_ack = accept;

  // Cell each bullet would enter on the next tick. Rows at or beyond ROWS
  // never match, so bullets below the grid fly freely.
  always_comb begin
    cell_hit = 3'b000;
    for (int s = 0; s < 3; s++) begin
      ny[s] = bullY[s] - 4'd1;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (ny[s] == 4'(r) && bullX[s] == 4'(c) && ddState[r][c] != 3'd0)
            cell_hit[s] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      cool      <= '0;
      hit_valid <= 3'b000;
      for (int s = 0; s < 3; s++) begin
        slot_st[s]   <= ST_FREE;
        bullState[s] <= 2'd0;
        bullX[s]     <= 4'd0;
        bullY[s]     <= 4'd0;
        hit_row[s]   <= 3'd0;
        hit_col[s]   <= 3'd0;
        hit_color[s] <= 2'd0;
      end
    end else begin
      hit_valid <= 3'b000;

      if (game_run)
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;

      if (accept)
        cool <= COOL_LOAD;
      else if (cool != '0)
        cool <= cool - 1'b1;

      for (int s = 0; s < 3; s++) begin
        if (accept && fire_slot[s]) begin
          // Fresh bullet sits at the spawn row even if this is a tick edge.
          slot_st[s]   <= ST_FLY;
          bullState[s] <= fire_color;
          bullX[s]     <= blockPos;
          bullY[s]     <= SPAWN_L;
        end else if (tick && slot_st[s] == ST_FLY) begin
          if (bullY[s] == 4'd0) begin
            slot_st[s]   <= ST_FREE;
            bullState[s] <= 2'd0;
            bullX[s]     <= 4'd0;
            bullY[s]     <= 4'd0;
          end else if (cell_hit[s]) begin
            slot_st[s]   <= ST_FREE;
            bullState[s] <= 2'd0;
            bullX[s]     <= 4'd0;
            bullY[s]     <= 4'd0;
            hit_valid[s] <= 1'b1;
            hit_row[s]   <= ny[s][2:0];
            hit_col[s]   <= bullX[s][2:0];
            hit_color[s] <= bullState[s];
          end else begin
            bullY[s] <= ny[s];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bullet_manager.sv
// Directed bench for bullet_manager with MOVE_DIV=4, COOLDOWN=2.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
module tb_bullet_manager;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       game_run;
  logic [3:0] blockPos;
  logic       fire_req;
  logic [1:0] fire_color;
  logic       fire_ack;
  logic [2:0] dd [0:4][0:5];
  logic [1:0] bullState [0:2];
  logic [3:0] bullX [0:2];
  logic [3:0] bullY [0:2];
  logic [2:0] hit_valid;
  logic [2:0] hit_row [0:2];
  logic [2:0] hit_col [0:2];
  logic [1:0] hit_color [0:2];

  int errors = 0;
  int checks = 0;
  logic [2:0] hit_seen;
  logic       ack_seen;

  always #5 clk = ~clk;

  bullet_manager #(.MOVE_DIV(4), .COOLDOWN(2)) dut (
    .clk(clk), .rst_n(rst_n), .game_run(game_run), .blockPos(blockPos),
    .fire_req(fire_req), .fire_color(fire_color), .fire_ack(fire_ack),
    .ddState(dd), .bullState(bullState), .bullX(bullX), .bullY(bullY),
    .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hit_color(hit_color)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      hit_seen = hit_seen | hit_valid;
      ack_seen = ack_seen | fire_ack;
    end
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_grid();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++)
        dd[r][c] = 3'd0;
  endtask

  // One reset edge; afterwards the tick counter is 0 and play is running.
  task automatic do_reset();
    rst_n = 1'b0; fire_req = 1'b0; game_run = 1'b1;
    run(1);
    rst_n = 1'b1;
    hit_seen = 3'b000; ack_seen = 1'b0;
  endtask

  task automatic check_slot(input string tag, input int s, input int st,
                            input int x, input int y);
    check({tag, "_state"}, int'(bullState[s]), st);
    check({tag, "_x"}, int'(bullX[s]), x);
    check({tag, "_y"}, int'(bullY[s]), y);
  endtask

  // Fires colours 1,2,3 into columns 0,1,2 with the request held; accepts
  // land on edges 1, 4 and 7 after reset.
  task automatic fill_three();
    fire_req = 1'b1; fire_color = 2'd1; blockPos = 4'd0; settle();
    check("fill_ack0", int'(fire_ack), 1);
    run(1);
    check("fill_cool_block", int'(fire_ack), 0);
    fire_color = 2'd2; blockPos = 4'd1;
    run(2); settle();
    check("fill_ack1", int'(fire_ack), 1);
    run(1);
    fire_color = 2'd3; blockPos = 4'd2;
    run(2); settle();
    check("fill_ack2", int'(fire_ack), 1);
    run(1);
  endtask

  initial begin
    rst_n = 1'b0; game_run = 1'b0; blockPos = 4'd0;
    fire_req = 1'b0; fire_color = 2'd0;
    hit_seen = 3'b000; ack_seen = 1'b0;
    clear_grid();

    // Reset state
    do_reset();
    for (int s = 0; s < 3; s++) check_slot("reset", s, 0, 0, 0);
    check("reset_hit", int'(hit_valid), 0);

    // 1: single bullet flies through an empty grid and exits the top
    fire_req = 1'b1; fire_color = 2'd2; blockPos = 4'd3; settle();
    check("t1_ack", int'(fire_ack), 1);
    run(1);
    check("t1_ack_cool", int'(fire_ack), 0);
    fire_req = 1'b0;
    check_slot("t1_spawn", 0, 2, 3, 15);
    run(3);  check("t1_y_tick1", int'(bullY[0]), 14);
    run(4);  check("t1_y_tick2", int'(bullY[0]), 13);
    run(52); check_slot("t1_tick15", 0, 2, 3, 0);
    run(4);  check_slot("t1_exit", 0, 0, 0, 0);
    check("t1_no_hit", int'(hit_seen), 0);

    // 2: hit on the bottom grid row
    do_reset();
    dd[4][3] = 3'd5;
    fire_req = 1'b1; fire_color = 2'd1; blockPos = 4'd3;
    run(1);
    fire_req = 1'b0;
    run(39);
    check("t2_y_before", int'(bullY[0]), 5);
    check("t2_no_early_hit", int'(hit_seen), 0);
    run(4);
    check("t2_hit_valid", int'(hit_valid), 1);
    check("t2_hit_row", int'(hit_row[0]), 4);
    check("t2_hit_col", int'(hit_col[0]), 3);
    check("t2_hit_color", int'(hit_color[0]), 1);
    check("t2_freed", int'(bullState[0]), 0);
    run(1);
    check("t2_pulse_end", int'(hit_valid), 0);
    clear_grid();

    // 3: held request fills all slots, fourth waits for a free slot
    do_reset();
    fill_three();
    check_slot("t3_s0", 0, 1, 0, 14);
    check_slot("t3_s1", 1, 2, 1, 15);
    check_slot("t3_s2", 2, 3, 2, 15);
    fire_color = 2'd2; blockPos = 4'd5;
    ack_seen = 1'b0;
    run(56);
    check("t3_no_ack_full", int'(ack_seen), 0);
    check_slot("t3_s0_top", 0, 1, 0, 0);
    run(1);
    check("t3_s0_freed", int'(bullState[0]), 0);
    check("t3_ack_after_free", int'(fire_ack), 1);
    run(1);
    fire_req = 1'b0;
    check_slot("t3_refill", 0, 2, 5, 15);
    check_slot("t3_s1_top", 1, 2, 1, 0);

    // 4: invalid colour and out-of-range column are rejected
    do_reset();
    fire_req = 1'b1; fire_color = 2'd0; blockPos = 4'd2; settle();
    check("t4_color0_ack", int'(fire_ack), 0);
    run(1);
    check("t4_color0_slot", int'(bullState[0]), 0);
    fire_color = 2'd1; blockPos = 4'd6; settle();
    check("t4_col6_ack", int'(fire_ack), 0);
    run(1);
    check("t4_col6_slot", int'(bullState[0]), 0);
    blockPos = 4'd2; settle();
    check("t4_no_cooldown", int'(fire_ack), 1);
    fire_req = 1'b0;

    // 5: two aligned bullets hit on the same tick
    do_reset();
    dd[4][1] = 3'd1; dd[4][4] = 3'd2;
    fire_req = 1'b1; fire_color = 2'd3; blockPos = 4'd1;
    run(1);
    fire_req = 1'b0; game_run = 1'b0;
    run(2);
    game_run = 1'b1; fire_req = 1'b1; fire_color = 2'd2; blockPos = 4'd4; settle();
    check("t5_ack2", int'(fire_ack), 1);
    run(1);
    fire_req = 1'b0;
    run(41);
    check("t5_y0", int'(bullY[0]), 5);
    check("t5_y1", int'(bullY[1]), 5);
    check("t5_no_early_hit", int'(hit_seen), 0);
    run(1);
    check("t5_hit_valid", int'(hit_valid), 3);
    check("t5_row0", int'(hit_row[0]), 4);
    check("t5_col0", int'(hit_col[0]), 1);
    check("t5_color0", int'(hit_color[0]), 3);
    check("t5_row1", int'(hit_row[1]), 4);
    check("t5_col1", int'(hit_col[1]), 4);
    check("t5_color1", int'(hit_color[1]), 2);
    clear_grid();

    // 6: pause freezes flight and fire; reset mid-flight clears everything
    do_reset();
    fill_three();
    fire_req = 1'b0;
    run(3);
    check_slot("t6_s0_run", 0, 1, 0, 13);
    check_slot("t6_s1_run", 1, 2, 1, 14);
    game_run = 1'b0; fire_req = 1'b1; fire_color = 2'd1; blockPos = 4'd0;
    settle();
    check("t6_pause_ack", int'(fire_ack), 0);
    ack_seen = 1'b0;
    run(12);
    check_slot("t6_s0_frozen", 0, 1, 0, 13);
    check_slot("t6_s2_frozen", 2, 3, 2, 14);
    check("t6_pause_no_ack", int'(ack_seen), 0);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1; fire_req = 1'b0;
    for (int s = 0; s < 3; s++) check_slot("t6_rst", s, 0, 0, 0);
    check("t6_rst_hit", int'(hit_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
